// File: rtl/video_pkg.sv
// Shared definitions for the synthetic video source.
// Contents: pattern select codes, frame-timing FSM state encoding,
// noise LFSR seed/tap constants and the LFSR step function.
package video_pkg;

  localparam logic [1:0] PAT_HRAMP = 2'd0;
  localparam logic [1:0] PAT_VRAMP = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_CONST = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_ACT  = 3'd2,
    ST_POST = 3'd3,
    ST_GAP  = 3'd4
  } state_e;

  // Fibonacci LFSR, taps 16,14,13,11 -> bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/video_pattern_pix.sv
// Pixel value generator: maps (x, y, pattern select, constant) to a gray value.
// Optional macro PATTERN_NOISE_EN adds salt-and-pepper noise from a 16-bit LFSR
// that is reseeded at every frame acceptance and advances once per href cycle.
// Ports:
//   clk, rst_n, seed_load, advance  (only with PATTERN_NOISE_EN)
//   x, y       : 11-bit pixel column / active line index
//   sel        : pattern code (video_pkg PAT_*)
//   const_val  : value for the constant pattern
//   gray       : combinational pixel value
module video_pattern_pix
  import video_pkg::*;
(
`ifdef PATTERN_NOISE_EN
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_load,
  input  logic        advance,
`endif
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic [1:0]  sel,
  input  logic [7:0]  const_val,
  output logic [7:0]  gray
);

  logic [7:0] clean_s;
  logic       unused_s;

  // Upper coordinate bits never reach the 8-bit patterns.
  assign unused_s = ^{x[10:8], y[10:8]};

  // Clean test pattern selection.
  always_comb begin
    clean_s = 8'h00;
    case (sel)
      PAT_HRAMP: clean_s = x[7:0];
      PAT_VRAMP: clean_s = y[7:0];
      PAT_CHECK: clean_s = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
      PAT_CONST: clean_s = const_val;
      default:   clean_s = 8'h00;
    endcase
  end

`ifdef PATTERN_NOISE_EN
  logic [15:0] lfsr_r;
  logic [15:0] lfsr_cur_s;

  // A seed load in the same cycle as the first pixel must already affect that pixel.
  assign lfsr_cur_s = seed_load ? LFSR_SEED : lfsr_r;

  // Noise LFSR state: reseeded per frame, stepped only on href cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r <= 16'h0000;
    end else if (advance) begin
      lfsr_r <= lfsr_step(lfsr_cur_s);
    end else begin
      lfsr_r <= lfsr_cur_s;
    end
  end

  // Replace roughly 1/64 of pixels by black or white.
  always_comb begin
    gray = clean_s;
    if (lfsr_cur_s[15:10] == 6'd0) begin
      gray = lfsr_cur_s[0] ? 8'hFF : 8'h00;
    end else begin
      gray = clean_s;
    end
  end
`else
  assign gray = clean_s;
`endif

endmodule

// File: rtl/video_pattern_gen.sv
// Synthetic video source producing a vsync/href/gray stream, one pixel per clock.
// Frame = V_PRE + IMG_VDISP + V_POST lines of (IMG_HDISP + H_BLANK) clocks with
// vsync high, followed by V_GAP clocks with vsync low.
// Optional macro PATTERN_NOISE_EN enables repeatable salt-and-pepper noise.
// Ports:
//   clk, rst_n        : pixel clock, async active-low reset
//   frame_start       : one-cycle request for one frame (ignored while busy)
//   continuous        : free-run frames back to back
//   pattern_sel       : 0 hramp, 1 vramp, 2 checker, 3 constant
//   const_val         : gray value for the constant pattern
//   busy              : frame accepted and not yet back in IDLE
//   frame_done        : one-cycle pulse on vsync falling
//   post_img_vsync/href/gray : registered video stream
module video_pattern_gen
  import video_pkg::*;
#(
  parameter logic [10:0] IMG_HDISP = 11'd400,
  parameter logic [10:0] IMG_VDISP = 11'd300,
  parameter logic [10:0] H_BLANK   = 11'd40,
  parameter logic [10:0] V_PRE     = 11'd2,
  parameter logic [10:0] V_POST    = 11'd2,
  parameter logic [10:0] V_GAP     = 11'd16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       continuous,
  input  logic [1:0] pattern_sel,
  input  logic [7:0] const_val,
  output logic       busy,
  output logic       frame_done,
  output logic       post_img_vsync,
  output logic       post_img_href,
  output logic [7:0] post_img_gray
);

  localparam logic [10:0] LINE_LEN = IMG_HDISP + H_BLANK;
  localparam state_e START_ST = (V_PRE != 11'd0) ? ST_PRE : ST_ACT;
  localparam state_e ACT_NEXT = (V_POST != 11'd0) ? ST_POST : ST_GAP;

  state_e      state_r, state_nxt_s, phase_next_s;
  logic [10:0] hcnt_r, hcnt_nxt_s;
  logic [10:0] vcnt_r, vcnt_nxt_s;
  logic [10:0] phase_len_s;
  logic        accept_s;
  logic        line_end_s;
  logic [1:0]  sel_r, sel_nxt_s;
  logic [7:0]  const_r, const_nxt_s;
  logic        vsync_nxt_s, href_nxt_s;
  logic [7:0]  pix_gray_s;

  assign line_end_s = (hcnt_r == (LINE_LEN - 11'd1));

  // Line count and successor for the vsync-high phase currently running.
  always_comb begin
    phase_len_s  = IMG_VDISP;
    phase_next_s = ACT_NEXT;
    case (state_r)
      ST_PRE: begin
        phase_len_s  = V_PRE;
        phase_next_s = ST_ACT;
      end
      ST_ACT: begin
        phase_len_s  = IMG_VDISP;
        phase_next_s = ACT_NEXT;
      end
      ST_POST: begin
        phase_len_s  = V_POST;
        phase_next_s = ST_GAP;
      end
      default: begin
        phase_len_s  = IMG_VDISP;
        phase_next_s = ACT_NEXT;
      end
    endcase
  end

  // Next-state and counter logic for the frame timing FSM.
  always_comb begin
    state_nxt_s = state_r;
    hcnt_nxt_s  = hcnt_r;
    vcnt_nxt_s  = vcnt_r;
    accept_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        hcnt_nxt_s = 11'd0;
        vcnt_nxt_s = 11'd0;
        if (frame_start || continuous) begin
          accept_s    = 1'b1;
          state_nxt_s = START_ST;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PRE, ST_ACT, ST_POST: begin
        if (line_end_s) begin
          hcnt_nxt_s = 11'd0;
          if (vcnt_r == (phase_len_s - 11'd1)) begin
            vcnt_nxt_s  = 11'd0;
            state_nxt_s = phase_next_s;
          end else begin
            vcnt_nxt_s = vcnt_r + 11'd1;
          end
        end else begin
          hcnt_nxt_s = hcnt_r + 11'd1;
        end
      end
      ST_GAP: begin
        // hcnt doubles as the gap clock counter.
        if (hcnt_r == (V_GAP - 11'd1)) begin
          hcnt_nxt_s = 11'd0;
          if (continuous) begin
            accept_s    = 1'b1;
            state_nxt_s = START_ST;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          hcnt_nxt_s = hcnt_r + 11'd1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        hcnt_nxt_s  = 11'd0;
        vcnt_nxt_s  = 11'd0;
      end
    endcase
  end

  // Pattern settings are frozen at acceptance; the acceptance cycle already uses the new ones.
  assign sel_nxt_s   = accept_s ? pattern_sel : sel_r;
  assign const_nxt_s = accept_s ? const_val   : const_r;

  // Outputs are registered from next-state values so they line up with the FSM.
  assign vsync_nxt_s = (state_nxt_s == ST_PRE) || (state_nxt_s == ST_ACT) ||
                       (state_nxt_s == ST_POST);
  assign href_nxt_s  = (state_nxt_s == ST_ACT) && (hcnt_nxt_s < IMG_HDISP);

  video_pattern_pix u_pix (
`ifdef PATTERN_NOISE_EN
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (accept_s),
    .advance   (href_nxt_s),
`endif
    .x         (hcnt_nxt_s),
    .y         (vcnt_nxt_s),
    .sel       (sel_nxt_s),
    .const_val (const_nxt_s),
    .gray      (pix_gray_s)
  );

  // FSM, counters, latched settings and registered video outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      hcnt_r         <= 11'd0;
      vcnt_r         <= 11'd0;
      sel_r          <= 2'd0;
      const_r        <= 8'h00;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      post_img_vsync <= 1'b0;
      post_img_href  <= 1'b0;
      post_img_gray  <= 8'h00;
    end else begin
      state_r        <= state_nxt_s;
      hcnt_r         <= hcnt_nxt_s;
      vcnt_r         <= vcnt_nxt_s;
      sel_r          <= sel_nxt_s;
      const_r        <= const_nxt_s;
      busy           <= (state_nxt_s != ST_IDLE);
      frame_done     <= post_img_vsync & ~vsync_nxt_s;
      post_img_vsync <= vsync_nxt_s;
      post_img_href  <= href_nxt_s;
      post_img_gray  <= href_nxt_s ? pix_gray_s : 8'h00;
    end
  end

endmodule
